segre_id_queue: RTL and testbench
=================================

SEGRE_ID_QUEUE -- requirements
Module: segre_id_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, meaning the number of IF->ID entries (power of two, >=2).
REQ-002 clk_i  in  1  core clock; all state SHALL update on its rising edge.
REQ-003 rsn_i  in  1  reset, asynchronous and active-low.
REQ-004 instr_i  in  WORD_SIZE  fetched instruction.
REQ-005 pc_i  in  ADDR_SIZE  PC of instr_i.
REQ-006 valid_if_i  in  1  IF offers instr_i/pc_i this cycle.
REQ-007 ready_if_o  out  1  queue accepts an offer this cycle.
REQ-008 block_id_i  in  1  decode stalled; head entry SHALL NOT be consumed.
REQ-009 flush_i  in  1  discard all entries (branch/jump redirect).
REQ-010 instr_o  out  WORD_SIZE  head instruction to decoder.
REQ-011 pc_o  out  ADDR_SIZE  head PC.
REQ-012 valid_o  out  1  head entry valid.
REQ-013 count_o  out  $clog2(DEPTH)+1  occupied entries.
REQ-014 finish_test_o  out  1  head is the end-of-test instruction.

Function
REQ-015 Push SHALL occur when valid_if_i && ready_if_o && !flush_i.
REQ-016 Pop SHALL occur when valid_o && !block_id_i && !flush_i.
REQ-017 ready_if_o SHALL equal (count_o != DEPTH), registered-state only, with no combinational path from block_id_i.
REQ-018 A pushed entry SHALL appear at the head no earlier than the cycle after the push: one-cycle latency when the queue is empty.
REQ-019 Simultaneous push and pop SHALL leave count_o unchanged and preserve FIFO order.
REQ-020 When full, a pop and an offer in the same cycle SHALL NOT push, because ready_if_o is 0.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 count_o SHALL never exceed DEPTH or underflow below 0.
REQ-023 flush_i SHALL, next cycle, set count_o=0, valid_o=0, and reset both pointers to 0.
REQ-024 flush_i SHALL override push and pop in the same cycle.
REQ-025 When empty, instr_o SHALL be NOP_INSTR, pc_o SHALL be PC_RESET_VAL (32'hfffffffc), and valid_o SHALL be 0.
REQ-026 When valid_o=1, instr_o/pc_o SHALL be the oldest unconsumed entry and SHALL remain stable while block_id_i=1.
REQ-027 valid_o SHALL equal (count_o != 0).

Reset
REQ-028 Asserting rsn_i low SHALL immediately (asynchronously) clear pointers and count; outputs then read as empty: valid_o=0, instr_o=NOP_INSTR, pc_o=32'hfffffffc, count_o=0, ready_if_o=1, finish_test_o=0.
REQ-029 Reset mid-operation SHALL discard all entries; no entry SHALL reappear after release.
REQ-030 Storage array contents SHALL NOT require reset; outputs SHALL be masked by valid_o.

Configuration
REQ-031 Macro SEGRE_FINISH_DETECT_EN defined: finish_test_o SHALL be valid_o && (instr_o == FINISH_INSTR), with FINISH_INSTR = 32'hfff01073.
REQ-032 Macro undefined: finish_test_o SHALL be constant 0 and no comparator SHALL be synthesised.

Structure
REQ-033 NOP_INSTR, FINISH_INSTR, PC_RESET_VAL, WORD_SIZE and ADDR_SIZE SHALL reside in segre_pkg.
REQ-034 The block SHALL be a single module with no sub-module; pointer/count logic and the DEPTH-entry array SHALL be inline.

Verification (DEPTH=2)
REQ-035 Reset release, then push instr 32'h00000013 pc 0x0 -> cycle+1: valid_o=1, instr_o=32'h00000013, pc_o=0x0, count_o=1.
REQ-036 Push 3 instrs back-to-back with block_id_i=1 -> third offer sees ready_if_o=0, count_o=2; release block -> pops pc 0x0 then 0x4 in order.
REQ-037 Full queue, flush_i=1 with valid_if_i=1 -> next cycle: count_o=0, valid_o=0, instr_o=NOP_INSTR, pc_o=32'hfffffffc; the offered instr is dropped.
REQ-038 count_o=1, simultaneous push pc 0x8 and pop -> count_o stays 1 and the head becomes pc 0x8; repeat 5 times to exercise pointer wrap.
REQ-039 Push 32'hfff01073 -> finish_test_o=1 the cycle it is head with SEGRE_FINISH_DETECT_EN defined, and 0 without it.
REQ-040 rsn_i driven low between clock edges with count_o=2 -> valid_o=0 and count_o=0 before the next edge.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared core constants for the segre pipeline: word/address sizes and
// special instruction/PC encodings used by the IF->ID queue.
package segre_pkg;

   localparam int WORD_SIZE = 32;
   localparam int ADDR_SIZE = 32;

   localparam logic [WORD_SIZE-1:0] NOP_INSTR    = 32'h00000013;
   localparam logic [WORD_SIZE-1:0] FINISH_INSTR = 32'hfff01073;
   localparam logic [ADDR_SIZE-1:0] PC_RESET_VAL = 32'hfffffffc;

endpackage : segre_pkg

// File: rtl/segre_id_queue.sv
// IF->ID decoupling FIFO with flush, decode back-pressure and empty-masked outputs.
// Optional macro SEGRE_FINISH_DETECT_EN enables end-of-test detection on the head entry.
module segre_id_queue
   import segre_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rsn_i,
   input  logic [WORD_SIZE-1:0]     instr_i,
   input  logic [ADDR_SIZE-1:0]     pc_i,
   input  logic                     valid_if_i,
   output logic                     ready_if_o,
   input  logic                     block_id_i,
   input  logic                     flush_i,
   output logic [WORD_SIZE-1:0]     instr_o,
   output logic [ADDR_SIZE-1:0]     pc_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     finish_test_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WORD_SIZE-1:0] instr_mem_r [DEPTH];
   logic [ADDR_SIZE-1:0] pc_mem_r    [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [CNT_W-1:0]     count_r;
   logic                 push_s;
   logic                 pop_s;
   logic                 empty_s;

   // Handshake decode; ready depends only on registered occupancy
   always_comb begin
      empty_s    = (count_r == CNT_W'(0));
      ready_if_o = (count_r != CNT_W'(DEPTH));
      valid_o    = !empty_s;
      push_s     = valid_if_i && ready_if_o && !flush_i;
      pop_s      = valid_o && !block_id_i && !flush_i;
   end

   // Pointer and occupancy state; flush dominates any push/pop
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else if (flush_i) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         else        wr_ptr_r <= wr_ptr_r;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         else        rd_ptr_r <= rd_ptr_r;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are never reset because outputs are masked when empty
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         instr_mem_r[wr_ptr_r] <= instr_i;
         pc_mem_r[wr_ptr_r]    <= pc_i;
      end
   end

   // Head presentation, forced to NOP/reset PC while empty
   always_comb begin
      count_o = count_r;
      if (empty_s) begin
         instr_o = NOP_INSTR;
         pc_o    = PC_RESET_VAL;
      end else begin
         instr_o = instr_mem_r[rd_ptr_r];
         pc_o    = pc_mem_r[rd_ptr_r];
      end
   end

`ifdef SEGRE_FINISH_DETECT_EN
   assign finish_test_o = valid_o && (instr_o == FINISH_INSTR);
`else
   assign finish_test_o = 1'b0;
`endif

endmodule : segre_id_queue

// File: tb/tb_segre_id_queue.sv
// Directed self-checking bench for segre_id_queue at DEPTH=2.
module tb_segre_id_queue;
   import segre_pkg::*;

   logic                 clk_i = 1'b0;
   logic                 rsn_i;
   logic [WORD_SIZE-1:0] instr_i;
   logic [ADDR_SIZE-1:0] pc_i;
   logic                 valid_if_i;
   logic                 ready_if_o;
   logic                 block_id_i;
   logic                 flush_i;
   logic [WORD_SIZE-1:0] instr_o;
   logic [ADDR_SIZE-1:0] pc_o;
   logic                 valid_o;
   logic [1:0]           count_o;
   logic                 finish_test_o;

   int n_cmp = 0;
   int n_err = 0;

`ifdef SEGRE_FINISH_DETECT_EN
   localparam logic FIN_EXP = 1'b1;
`else
   localparam logic FIN_EXP = 1'b0;
`endif

   segre_id_queue #(.DEPTH(2)) dut (
      .clk_i(clk_i), .rsn_i(rsn_i), .instr_i(instr_i), .pc_i(pc_i),
      .valid_if_i(valid_if_i), .ready_if_o(ready_if_o), .block_id_i(block_id_i),
      .flush_i(flush_i), .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o),
      .count_o(count_o), .finish_test_o(finish_test_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      valid_if_i = 1'b0;
      block_id_i = 1'b0;
      flush_i    = 1'b0;
      instr_i    = 32'h0;
      pc_i       = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rsn_i = 1'b0;
      #2;
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", valid_o); end
      n_cmp++; if (instr_o !== NOP_INSTR) begin n_err++; $display("FAIL rst_instr got %h want %h", instr_o, NOP_INSTR); end
      n_cmp++; if (pc_o !== 32'hfffffffc) begin n_err++; $display("FAIL rst_pc got %h want fffffffc", pc_o); end
      n_cmp++; if (count_o !== 2'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count_o); end
      n_cmp++; if (ready_if_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", ready_if_o); end
      n_cmp++; if (finish_test_o !== 1'b0) begin n_err++; $display("FAIL rst_finish got %b want 0", finish_test_o); end
      @(negedge clk_i);
      rsn_i = 1'b1;
      step();
   endtask

   task automatic test_single_push();
      valid_if_i = 1'b1; instr_i = 32'h00000013; pc_i = 32'h0;
      step();
      valid_if_i = 1'b0;
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL push_valid got %b want 1", valid_o); end
      n_cmp++; if (instr_o !== 32'h00000013) begin n_err++; $display("FAIL push_instr got %h want 00000013", instr_o); end
      n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL push_pc got %h want 0", pc_o); end
      n_cmp++; if (count_o !== 2'd1) begin n_err++; $display("FAIL push_count got %0d want 1", count_o); end
      step();
      n_cmp++; if (count_o !== 2'd0 || valid_o !== 1'b0) begin n_err++; $display("FAIL pop_empty got cnt=%0d v=%b want 0/0", count_o, valid_o); end
   endtask

   task automatic test_back_to_back();
      block_id_i = 1'b1;
      valid_if_i = 1'b1; instr_i = 32'h00100093; pc_i = 32'h0;
      step();
      instr_i = 32'h00200113; pc_i = 32'h4;
      step();
      instr_i = 32'h00300193; pc_i = 32'h8;
      n_cmp++; if (ready_if_o !== 1'b0) begin n_err++; $display("FAIL b2b_ready got %b want 0", ready_if_o); end
      n_cmp++; if (count_o !== 2'd2) begin n_err++; $display("FAIL b2b_full got %0d want 2", count_o); end
      step();
      valid_if_i = 1'b0;
      n_cmp++; if (count_o !== 2'd2 || pc_o !== 32'h0) begin n_err++; $display("FAIL b2b_hold got cnt=%0d pc=%h want 2/0", count_o, pc_o); end
      block_id_i = 1'b0;
      step();
      n_cmp++; if (pc_o !== 32'h4 || instr_o !== 32'h00200113 || count_o !== 2'd1) begin n_err++; $display("FAIL b2b_pop1 got pc=%h ins=%h cnt=%0d want 4/00200113/1", pc_o, instr_o, count_o); end
      step();
      n_cmp++; if (count_o !== 2'd0 || pc_o !== 32'hfffffffc) begin n_err++; $display("FAIL b2b_pop2 got cnt=%0d pc=%h want 0/fffffffc", count_o, pc_o); end
   endtask

   task automatic test_flush();
      block_id_i = 1'b1; valid_if_i = 1'b1;
      instr_i = 32'h11111111; pc_i = 32'h20; step();
      instr_i = 32'h22222222; pc_i = 32'h24; step();
      flush_i = 1'b1; instr_i = 32'h33333333; pc_i = 32'h28;
      step();
      flush_i = 1'b0; valid_if_i = 1'b0; block_id_i = 1'b0;
      n_cmp++; if (count_o !== 2'd0 || valid_o !== 1'b0) begin n_err++; $display("FAIL flush_empty got cnt=%0d v=%b want 0/0", count_o, valid_o); end
      n_cmp++; if (instr_o !== NOP_INSTR || pc_o !== 32'hfffffffc) begin n_err++; $display("FAIL flush_outs got ins=%h pc=%h want %h/fffffffc", instr_o, pc_o, NOP_INSTR); end
      step();
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_drop got v=%b want 0", valid_o); end
   endtask

   task automatic test_wrap();
      logic [31:0] pcs [5];
      pcs[0] = 32'h8; pcs[1] = 32'hc; pcs[2] = 32'h10; pcs[3] = 32'h14; pcs[4] = 32'h18;
      block_id_i = 1'b1; valid_if_i = 1'b1; instr_i = 32'h0a000013; pc_i = 32'h4;
      step();
      block_id_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         instr_i = 32'h0b000013 + 32'(i); pc_i = pcs[i];
         step();
         n_cmp++;
         if (count_o !== 2'd1 || pc_o !== pcs[i] || instr_o !== 32'h0b000013 + 32'(i)) begin
            n_err++; $display("FAIL wrap_%0d got cnt=%0d pc=%h want 1/%h", i, count_o, pc_o, pcs[i]);
         end
      end
      valid_if_i = 1'b0;
      step();
      n_cmp++; if (count_o !== 2'd0) begin n_err++; $display("FAIL wrap_drain got %0d want 0", count_o); end
   endtask

   task automatic test_finish();
      block_id_i = 1'b1; valid_if_i = 1'b1; instr_i = 32'hfff01073; pc_i = 32'h40;
      step();
      instr_i = 32'h00000013; pc_i = 32'h44;
      n_cmp++; if (finish_test_o !== FIN_EXP) begin n_err++; $display("FAIL finish_head got %b want %b", finish_test_o, FIN_EXP); end
      step();
      valid_if_i = 1'b0; block_id_i = 1'b0;
      step();
      n_cmp++; if (finish_test_o !== 1'b0 || pc_o !== 32'h44) begin n_err++; $display("FAIL finish_next got f=%b pc=%h want 0/44", finish_test_o, pc_o); end
      step();
   endtask

   task automatic test_async_reset();
      block_id_i = 1'b1; valid_if_i = 1'b1;
      instr_i = 32'h44444444; pc_i = 32'h50; step();
      instr_i = 32'h55555555; pc_i = 32'h54; step();
      valid_if_i = 1'b0;
      n_cmp++; if (count_o !== 2'd2) begin n_err++; $display("FAIL arst_pre got %0d want 2", count_o); end
      #2 rsn_i = 1'b0;
      #1;
      n_cmp++; if (valid_o !== 1'b0 || count_o !== 2'd0 || ready_if_o !== 1'b1) begin n_err++; $display("FAIL arst_async got v=%b cnt=%0d r=%b want 0/0/1", valid_o, count_o, ready_if_o); end
      @(negedge clk_i);
      rsn_i = 1'b1; block_id_i = 1'b0;
      step();
      n_cmp++; if (valid_o !== 1'b0 || count_o !== 2'd0 || pc_o !== 32'hfffffffc) begin n_err++; $display("FAIL arst_after got v=%b cnt=%0d pc=%h want 0/0/fffffffc", valid_o, count_o, pc_o); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_back_to_back();
      test_flush();
      test_wrap();
      test_finish();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_segre_id_queue
